toupper_stream_arbiter: RTL
===========================

# toupper_stream_arbiter

Shares one ASCII lowercase-to-uppercase conversion datapath between two byte-stream requesters. A packet-locked round-robin arbiter grants one requester at a time. Each accepted byte passes through the case-conversion function (0x61–0x7A minus 0x20, all other codes unchanged) and lands in a single registered output stage with valid/ready backpressure. The block sits between the text-source front ends and the downstream uppercase consumer.

## Interface
- No parameters. The byte width is fixed at 8 and the requester count is fixed at 2.
- `clk`  in  1  — the single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `s0_valid`  in  1  — requester 0 has a byte.
- `s0_data`  in  8  — requester 0 byte.
- `s0_last`  in  1  — final byte of the requester 0 packet.
- `s0_ready`  out  1  — requester 0 byte accepted this cycle when `s0_valid` is also high.
- `s1_valid`, `s1_data`, `s1_last`, `s1_ready` — same as requester 0, for requester 1.
- `conv_en`  in  2  — bit k=1 uppercases bytes from requester k; bit k=0 passes them through unchanged.
- `m_valid`  out  1  — the output register holds a byte.
- `m_data`  out  8  — the converted byte.
- `m_last`  out  1  — copy of the source's last flag.
- `m_src`  out  1  — index of the requester that produced `m_data`.
- `m_ready`  in  1  — the consumer takes the byte when `m_valid` and `m_ready` are both high.
- `busy`  out  1  — high when the state is not IDLE or `m_valid`=1.

## Operation
- **States:**
  - IDLE: no requester is granted.
  - GNT0: requester 0 is granted and locked until the end of its packet.
  - GNT1: requester 1 is granted and locked until the end of its packet.
- **Round-robin pointer `rr`:**
  - Reset value 0.
  - `rr` names the preferred requester.
- **Leaving IDLE:**
  - Both `s0_valid` and `s1_valid` high: go to GNT[rr].
  - Only one valid high: go to that requester's grant state.
  - Neither valid high: stay in IDLE.
  - No byte is accepted in an IDLE cycle.
- **Accept condition in GNTk:** `sk_ready` = (!`m_valid` | `m_ready`). It is combinational from the state, `m_valid` and `m_ready`. The non-granted requester's ready is 0. `s*_ready` is 0 in IDLE.
- **On accept:**
  - `m_data` <= convert(`sk_data`, `conv_en[k]`).
  - `m_last` <= `sk_last`.
  - `m_src` <= k.
  - `m_valid` <= 1.
  - `conv_en` is sampled at accept time only.
- **convert(d, en):**
  - If en and 8'h61 ≤ d ≤ 8'h7A: result is d − 8'h20.
  - Otherwise: result is d.
  - Bytes ≥ 8'h80 and the control codes are never modified.
- **Grant release:**
  - An accept with `sk_last`=1 moves the state to IDLE and sets `rr` <= ~k.
  - The grant is never released mid-packet. If `sk_valid` drops, the state holds GNTk and waits.
- **Output register:**
  - A handshake without a simultaneous accept clears `m_valid`.
  - A simultaneous handshake and accept reloads the register. Throughput is then 1 byte/cycle.
  - While `m_valid`=1 and `m_ready`=0, `m_data`, `m_last` and `m_src` hold stable.

## Timing
- **Reset values:** state IDLE, `rr`=0, `m_valid`=0, `m_data`=8'h00, `m_last`=0, `m_src`=0, `busy`=0. `s0_ready` and `s1_ready` read 0 in IDLE.
- **Reset mid-packet:** the output register contents are discarded, the grant is dropped and `rr` returns to 0. The next packet starts from arbitration.
- **Latency:**
  - A byte accepted at edge N is visible on `m_*` after edge N (cycle N+1).
  - The first byte of a packet is accepted no earlier than one cycle after the requester's `valid` rises while the block is in IDLE (the arbitration cycle).
- **Inter-packet gap:** one bubble cycle in IDLE between packets, including single-byte packets (`last`=1 on the first beat).
- **Simultaneous requests at IDLE:** `rr` decides. Alternation is guaranteed when both requesters stream continuously.
- **Backpressure:**
  - With `m_ready`=0 and `m_valid`=1, `sk_ready`=0 and no byte is lost.
  - When `m_ready` rises, the held byte and a new byte transfer on the same edge.
- **Invariant:** a requester change never occurs while a packet is open. `m_src` bytes of one packet are contiguous on the output.

## Test plan
- **Reset, then s0 packet** {8'h61, 8'h7A, 8'h28(last)}, `conv_en`=2'b01, `m_ready`=1 → `m_data` 8'h41, 8'h5A, 8'h28; `m_last` only on 8'h28; `m_src`=0; first output 2 cycles after `s0_valid`.
- **Pass-through and non-ASCII:** s1 sends {8'h6D, 8'hEB, 8'h7B, 8'h7F(last)} with `conv_en`=2'b00 → output identical to input. Repeat with `conv_en`=2'b10 → 8'h4D, 8'hEB, 8'h7B, 8'h7F.
- **Both requesters valid continuously with 2-byte packets after reset** → grants go s0, s1, s0, s1; each packet contiguous; one IDLE bubble between packets; `rr` toggles after each `last`.
- **Backpressure:** hold `m_ready`=0 for 5 cycles while s0 streams → `m_valid`=1 with stable `m_data`; `s0_ready`=0; no byte dropped or duplicated once `m_ready`=1.
- **Mid-packet valid gap:** s0 drops `valid` for 3 cycles before `last` while s1 is requesting → s1 is never granted until s0's `last` is accepted.
- **Reset mid-packet with `m_valid`=1** → next cycle `m_valid`=0, `busy`=0, state IDLE; new requests arbitrate with `rr`=0.

Source files
------------

// File: rtl/toupper_stream_arbiter_if.sv
// Byte-stream handshake bundle shared by the two requesters and the consumer port.
// The producer drives valid/data/last and the consumer drives ready.
interface toupper_stream_arbiter_if;
   logic       valid;
   logic [7:0] data;
   logic       last;
   logic       ready;

   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/toupper_stream_arbiter.sv
// Two-requester, packet-locked round-robin arbiter feeding a shared ASCII
// lowercase-to-uppercase converter with a single registered output stage.
module toupper_stream_arbiter (
   input  logic                            clk,
   input  logic                            rst,
   toupper_stream_arbiter_if.slave         s0,
   toupper_stream_arbiter_if.slave         s1,
   toupper_stream_arbiter_if.master        m,
   input  logic [1:0]                      conv_en,
   output logic                            m_src,
   output logic                            busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

   state_e     state_q;
   logic       rr_q;
   logic       m_valid_q;
   logic [7:0] m_data_q;
   logic       m_last_q;
   logic       m_src_q;

   logic       out_free;
   logic       rdy0;
   logic       rdy1;
   logic       acc0;
   logic       acc1;
   logic       accept;
   logic       sel_last;
   logic       sel_en;
   logic [7:0] sel_data;
   logic [7:0] m_data_d;

   function automatic logic [7:0] convert(input logic [7:0] d, input logic en);
      if (en && (d >= 8'h61) && (d <= 8'h7A)) return d - 8'h20;
      return d;
   endfunction

   // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
   always_comb begin
      out_free = !m_valid_q || m.ready;
      rdy0     = (state_q == GNT0) && out_free;
      rdy1     = (state_q == GNT1) && out_free;
      acc0     = rdy0 && s0.valid;
      acc1     = rdy1 && s1.valid;
      accept   = acc0 || acc1;
      sel_data = acc1 ? s1.data : s0.data;
      sel_last = acc1 ? s1.last : s0.last;
      sel_en   = acc1 ? conv_en[1] : conv_en[0];
      m_data_d = convert(sel_data, sel_en);

      s0.ready = rdy0;
      s1.ready = rdy1;
      m.valid  = m_valid_q;
      m.data   = m_data_q;
      m.last   = m_last_q;
      m_src    = m_src_q;
      busy     = (state_q != IDLE) || m_valid_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h00;
         m_last_q  <= 1'b0;
         m_src_q   <= 1'b0;
      end else begin
         // A new accept reloads the stage; otherwise a consumer handshake empties it.
         if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= m_data_d;
            m_last_q  <= sel_last;
            m_src_q   <= acc1;
         end else if (m.ready) begin
            m_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (s0.valid && s1.valid) state_q <= rr_q ? GNT1 : GNT0;
               else if (s0.valid)        state_q <= GNT0;
               else if (s1.valid)        state_q <= GNT1;
            end
            GNT0: begin
               if (acc0 && s0.last) begin
                  state_q <= IDLE;
                  rr_q    <= 1'b1;
               end
            end
            GNT1: begin
               if (acc1 && s1.last) begin
                  state_q <= IDLE;
                  rr_q    <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
